// File: rtl/decode_stage_ctrl.sv
// rtl/decode_stage_ctrl.sv - decode-stage controller: two-entry skid buffer, immediate generation, load-use bubbles
// Immediates are formed at capture so the main/skid entries carry them ready for execute.
module decode_stage_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_ins,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  output logic        id_valid,
  output logic [31:0] id_ins,
  output logic [31:0] id_pc,
  output logic [31:0] id_imm,
  input  logic        ex_ready,
  input  logic        ex_load_valid,
  input  logic [4:0]  ex_load_rd,
  input  logic        flush,
  output logic [15:0] stall_cnt
);

  // State encoding is {main_valid, skid_valid}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    TWO   = 2'b11
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] main_ins, main_pc, main_imm;
  logic [31:0] skid_ins, skid_pc, skid_imm;
  logic        main_valid, skid_valid;
  logic        load_main_in, load_main_skid, load_skid_in;
  logic        use_rs1, use_rs2, hazard, if_fire, deq;

  function automatic logic [31:0] calc_imm(input logic [31:0] ins);
    logic [31:0] imm;
    case (ins[6:2])
      5'b01000: imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      5'b01101: imm = {ins[31:12], 12'b0};
      default:  imm = {{20{ins[31]}}, ins[31:20]};
    endcase
    return imm;
  endfunction

  assign main_valid = state[1];
  assign skid_valid = state[0];

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (main_ins[6:2])
      5'b00100, 5'b00000: use_rs1 = 1'b1;
      5'b01000, 5'b01100: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  assign hazard = main_valid && ex_load_valid && (ex_load_rd != 5'd0) &&
                  ((use_rs1 && (ex_load_rd == main_ins[19:15])) ||
                   (use_rs2 && (ex_load_rd == main_ins[24:20])));

  assign if_ready = !skid_valid && !rst;
  assign id_valid = main_valid && !hazard;
  assign if_fire  = if_valid && if_ready;
  assign deq      = id_valid && ex_ready;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (if_fire) begin
            state_nxt    = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (deq && if_fire) begin
            load_main_in = 1'b1;
          end else if (deq) begin
            state_nxt = EMPTY;
          end else if (if_fire) begin
            state_nxt    = TWO;
            load_skid_in = 1'b1;
          end
        end
        TWO: begin
          if (deq) begin
            state_nxt      = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      main_ins  <= 32'h0;
      main_pc   <= 32'h0;
      main_imm  <= 32'h0;
      skid_ins  <= 32'h0;
      skid_pc   <= 32'h0;
      skid_imm  <= 32'h0;
      stall_cnt <= 16'h0;
    end else begin
      state <= state_nxt;
      if (load_main_in) begin
        main_ins <= if_ins;
        main_pc  <= if_pc;
        main_imm <= calc_imm(if_ins);
      end else if (load_main_skid) begin
        main_ins <= skid_ins;
        main_pc  <= skid_pc;
        main_imm <= skid_imm;
      end
      if (load_skid_in) begin
        skid_ins <= if_ins;
        skid_pc  <= if_pc;
        skid_imm <= calc_imm(if_ins);
      end
      // Saturating bubble counter; a flush cycle is not a stall
      if (hazard && !flush && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign id_ins = main_ins;
  assign id_pc  = main_pc;
  assign id_imm = main_imm;

endmodule
